// File: rtl/activate_quant_pipe_pkg.sv
// rtl/activate_quant_pipe_pkg.sv - activation mode encodings and shift helper for the quantiser pipe
package nna_act_pkg;

    typedef enum logic [1:0] {
        ACT_BYPASS = 2'd0,
        ACT_RELU   = 2'd1,
        ACT_LEAKY  = 2'd2,
        ACT_CLIP   = 2'd3
    } act_mode_e;

    localparam int SHIFT_W = 6;

    // Requantisation shift in+weight-out, clamped to [0, max_shift].
    function automatic logic [SHIFT_W-1:0] clamp_shift(
        input logic [3:0]  fea_in,
        input logic [3:0]  weight,
        input logic [3:0]  fea_out,
        input int unsigned max_shift
    );
        logic signed [SHIFT_W-1:0] s;
        s = $signed({2'b00, fea_in}) + $signed({2'b00, weight}) - $signed({2'b00, fea_out});
        if (s < 0)
            clamp_shift = '0;
        else if (int'(s) > int'(max_shift))
            clamp_shift = SHIFT_W'(max_shift);
        else
            clamp_shift = $unsigned(s);
    endfunction

endpackage

// File: rtl/activate_quant_pipe_if.sv
// rtl/activate_quant_pipe_if.sv - MAC-result input stream and feature output stream
interface activate_quant_pipe_if #(
    parameter int CH = 8,
    parameter int M  = 36,
    parameter int F  = 16
);
    logic [CH*M-1:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic [CH*F-1:0] out_data;
    logic [CH-1:0]   out_sat;
    logic            out_valid;
    logic            out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_sat, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_sat, out_valid
    );
endinterface

// File: rtl/activate_quant_pipe_lane.sv
// rtl/activate_quant_pipe_lane.sv - one lane: threshold/activation, round-shift, saturate/clip
module act_quant_lane
    import nna_act_pkg::*;
#(
    parameter int M = 36,
    parameter int F = 16
) (
    input  logic               system_clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [M-1:0]       in_data,
    input  logic [M-1:0]       threshold,
    input  logic [1:0]         act_mode,
    input  logic [2:0]         leaky_shift,
    input  logic [SHIFT_W-1:0] shift,
    input  logic               round_en,
    input  logic [F-1:0]       clip_max,
    output logic [F-1:0]       out_data,
    output logic               out_sat
);
    localparam logic signed [M:0] SAT_MAX = {{(M-F+2){1'b0}}, {(F-1){1'b1}}};
    localparam logic signed [M:0] SAT_MIN = {{(M-F+2){1'b1}}, {(F-1){1'b0}}};
    localparam logic [F-1:0]      F_MAX   = {1'b0, {(F-1){1'b1}}};
    localparam logic [F-1:0]      F_MIN   = {1'b1, {(F-1){1'b0}}};

    act_mode_e           mode;
    logic signed [M-1:0] diff;
    logic signed [M-1:0] act_d;
    logic signed [M-1:0] s1_q;
    logic signed [M:0]   ext;
    logic signed [M:0]   half;
    logic signed [M:0]   rounded;
    logic signed [M:0]   s2_q;
    logic                sat_hi;
    logic                sat_lo;
    logic                clip_hit;
    logic [F-1:0]        res;

    assign mode = act_mode_e'(act_mode);
    assign diff = $signed(in_data - threshold);

    always_comb begin
        act_d = diff;
        if (diff < 0) begin
            case (mode)
                ACT_RELU, ACT_CLIP: act_d = '0;
                ACT_LEAKY:          act_d = diff >>> leaky_shift;
                default:            act_d = diff;
            endcase
        end
    end

    // One extra bit so adding the rounding half can never overflow.
    assign ext  = {s1_q[M-1], s1_q};
    assign half = (M+1)'(1) << (shift - 1'b1);

    always_comb begin
        if (round_en && shift != '0)
            rounded = (ext + half) >>> shift;
        else
            rounded = ext >>> shift;
    end

    always_comb begin
        sat_hi = s2_q > SAT_MAX;
        sat_lo = s2_q < SAT_MIN;
        if (sat_hi)
            res = F_MAX;
        else if (sat_lo)
            res = F_MIN;
        else
            res = s2_q[F-1:0];
        clip_hit = (mode == ACT_CLIP) && ($signed({res[F-1], res}) > $signed({1'b0, clip_max}));
        if (clip_hit)
            res = clip_max;
    end

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= '0;
            s2_q     <= '0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else if (en) begin
            s1_q     <= act_d;
            s2_q     <= rounded;
            out_data <= res;
            out_sat  <= sat_hi | sat_lo | clip_hit;
        end
    end

endmodule

// File: rtl/activate_quant_pipe.sv
// rtl/activate_quant_pipe.sv - CH-lane activation and requantisation pipe with valid/ready flow control
module activate_quant_pipe
    import nna_act_pkg::*;
#(
    parameter int CH               = 8,
    parameter int MAC_OUTPUT_WIDTH = 36,
    parameter int FEATURE_WIDTH    = 16
) (
    input  logic                        system_clk,
    input  logic                        rst_n,
    activate_quant_pipe_if.slave        stream,
    input  logic [1:0]                  act_mode,
    input  logic [2:0]                  leaky_shift,
    input  logic [3:0]                  fea_in_quant_size,
    input  logic [3:0]                  weight_quant_size,
    input  logic [3:0]                  fea_out_quant_size,
    input  logic                        round_en,
    input  logic [FEATURE_WIDTH-1:0]    clip_max,
    input  logic [MAC_OUTPUT_WIDTH-1:0] negedge_threshold
);
    localparam int M = MAC_OUTPUT_WIDTH;
    localparam int F = FEATURE_WIDTH;

    logic               en;
    logic               v1;
    logic               v2;
    logic               v3;
    logic [SHIFT_W-1:0] shift_q;
    logic [CH*F-1:0]    lane_data;
    logic [CH-1:0]      lane_sat;

    // Whole pipe advances together; in_ready follows out_ready combinationally.
    assign en               = !v3 || stream.out_ready;
    assign stream.in_ready  = en;
    assign stream.out_valid = v3;
    assign stream.out_data  = lane_data;
    assign stream.out_sat   = lane_sat;

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            v3      <= 1'b0;
            shift_q <= '0;
        end else if (en) begin
            v1      <= stream.in_valid;
            v2      <= v1;
            v3      <= v2;
            shift_q <= clamp_shift(fea_in_quant_size, weight_quant_size,
                                   fea_out_quant_size, M - 1);
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_lane
        act_quant_lane #(
            .M (M),
            .F (F)
        ) u_lane (
            .system_clk  (system_clk),
            .rst_n       (rst_n),
            .en          (en),
            .in_data     (stream.in_data[i*M +: M]),
            .threshold   (negedge_threshold),
            .act_mode    (act_mode),
            .leaky_shift (leaky_shift),
            .shift       (shift_q),
            .round_en    (round_en),
            .clip_max    (clip_max),
            .out_data    (lane_data[i*F +: F]),
            .out_sat     (lane_sat[i])
        );
    end

endmodule

// File: tb/tb_activate_quant_pipe.sv
// tb/tb_activate_quant_pipe.sv - self-checking bench for activate_quant_pipe
module tb_activate_quant_pipe;
    localparam int CH = 8;
    localparam int M  = 36;
    localparam int F  = 16;

    logic          system_clk = 1'b0;
    logic          rst_n      = 1'b0;
    logic [1:0]    act_mode   = 2'd1;
    logic [2:0]    leaky_shift = 3'd0;
    logic [3:0]    fea_in_quant_size  = 4'd8;
    logic [3:0]    weight_quant_size  = 4'd8;
    logic [3:0]    fea_out_quant_size = 4'd8;
    logic          round_en   = 1'b1;
    logic [F-1:0]  clip_max   = '0;
    logic [M-1:0]  negedge_threshold = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;
    logic [CH*F+CH-1:0] exp_q[$];
    logic               held = 1'b0;
    logic [CH*F+CH-1:0] held_val;

    activate_quant_pipe_if #(.CH(CH), .M(M), .F(F)) bus ();

    activate_quant_pipe #(
        .CH               (CH),
        .MAC_OUTPUT_WIDTH (M),
        .FEATURE_WIDTH    (F)
    ) dut (
        .system_clk         (system_clk),
        .rst_n              (rst_n),
        .stream             (bus),
        .act_mode           (act_mode),
        .leaky_shift        (leaky_shift),
        .fea_in_quant_size  (fea_in_quant_size),
        .weight_quant_size  (weight_quant_size),
        .fea_out_quant_size (fea_out_quant_size),
        .round_en           (round_en),
        .clip_max           (clip_max),
        .negedge_threshold  (negedge_threshold)
    );

    always #5 system_clk = ~system_clk;

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint fdiv(input longint a, input longint p);
        longint q;
        q = a / p;
        if ((a % p) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic longint wrap_m(input longint x);
        longint m;
        m = longint'(1) <<< M;
        x = x % m;
        if (x < 0) x = x + m;
        if (x >= m / 2) x = x - m;
        return x;
    endfunction

    // Reference: plain integer arithmetic on the current configuration.
    function automatic logic [CH*F+CH-1:0] model(input logic [CH*M-1:0] din);
        logic [CH*F-1:0] dout;
        logic [CH-1:0]   sat;
        logic [M-1:0]    lane;
        longint d, r, v, thr;
        int s;
        thr = longint'($signed(negedge_threshold));
        s = int'(fea_in_quant_size) + int'(weight_quant_size) - int'(fea_out_quant_size);
        if (s < 0) s = 0;
        if (s > M - 1) s = M - 1;
        for (int i = 0; i < CH; i++) begin
            lane = din[i*M +: M];
            d = wrap_m(longint'($signed(lane)) - thr);
            if (d < 0) begin
                if (act_mode == 2'd1 || act_mode == 2'd3) d = 0;
                else if (act_mode == 2'd2) d = fdiv(d, longint'(1) << leaky_shift);
            end
            if (round_en && s > 0) r = fdiv(d + (longint'(1) << (s - 1)), longint'(1) << s);
            else                   r = fdiv(d, longint'(1) << s);
            v = r;
            if (v > 32767)  v = 32767;
            if (v < -32768) v = -32768;
            if (act_mode == 2'd3 && v > longint'(clip_max)) v = longint'(clip_max);
            dout[i*F +: F] = v[F-1:0];
            sat[i] = (v != r);
        end
        return {sat, dout};
    endfunction

    function automatic logic [M-1:0] rand_lane();
        longint v;
        v = longint'({$urandom, $urandom});
        v = v >>> $urandom_range(0, 40);
        return v[M-1:0];
    endfunction

    function automatic logic [CH*M-1:0] rand_beat();
        logic [CH*M-1:0] b;
        for (int i = 0; i < CH; i++) b[i*M +: M] = rand_lane();
        return b;
    endfunction

    // Scoreboard: pushes model results on accept, compares on output handshake.
    always @(negedge system_clk) begin
        logic [CH*F+CH-1:0] e;
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.in_data));
            if (bus.out_valid) begin
                if (held) check("stall_stable", {bus.out_sat, bus.out_data}, held_val);
                if (bus.out_ready) begin
                    held = 1'b0;
                    n_out++;
                    if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        check("beat_data", bus.out_data, e[CH*F-1:0]);
                        check("beat_sat", bus.out_sat, e[CH*F+CH-1:CH*F]);
                    end
                end else begin
                    held = 1'b1;
                    held_val = {bus.out_sat, bus.out_data};
                end
            end else held = 1'b0;
        end else held = 1'b0;
    end

    task automatic tick();
        @(posedge system_clk);
        #1;
    endtask

    task automatic set_cfg(input logic [1:0] mode, input logic [2:0] ls, input logic [3:0] fi,
                           input logic [3:0] w, input logic [3:0] fo, input logic rnd,
                           input logic [F-1:0] clip, input longint thr);
        act_mode = mode; leaky_shift = ls;
        fea_in_quant_size = fi; weight_quant_size = w; fea_out_quant_size = fo;
        round_en = rnd; clip_max = clip; negedge_threshold = thr[M-1:0];
    endtask

    task automatic send_directed(input string tag, input longint l0, input longint l1,
                                 input longint e0, input longint e1, input logic s0, input logic s1);
        logic [CH*M-1:0] d;
        logic [63:0] t0, t1, x0, x1;
        int lat;
        bit got;
        t0 = l0; t1 = l1; x0 = e0; x1 = e1;
        d = rand_beat();
        d[0 +: M] = t0[M-1:0];
        d[M +: M] = t1[M-1:0];
        bus.out_ready = 1'b1;
        bus.in_data   = d;
        bus.in_valid  = 1'b1;
        #1;
        check({tag, "_in_ready"}, bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        got = 0;
        while (lat < 20 && !got) begin
            if (bus.out_valid) got = 1;
            else begin tick(); lat++; end
        end
        check({tag, "_latency"}, lat, 3);
        check({tag, "_lane0"}, bus.out_data[0 +: F], x0[F-1:0]);
        check({tag, "_lane1"}, bus.out_data[F +: F], x1[F-1:0]);
        check({tag, "_sat0"}, bus.out_sat[0], s0);
        check({tag, "_sat1"}, bus.out_sat[1], s1);
        tick();
    endtask

    task automatic drain(input string tag);
        int c;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        c = 0;
        while (c < 20 && (exp_q.size() != 0 || bus.out_valid)) begin tick(); c++; end
        check({tag, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        logic [CH*M-1:0] beats[6];
        int sent, cyc, start, seen, acc;

        bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        rst_n = 1'b0;
        tick(); tick();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_sat", bus.out_sat, 0);
        check("rst_in_ready", bus.in_ready, 1);
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", bus.in_ready, 1);

        set_cfg(2'd1, 3'd0, 4'd8, 4'd8, 4'd8, 1'b1, 16'd0, 0);
        send_directed("relu_rnd", 384, -1000, 2, 0, 0, 0);
        set_cfg(2'd1, 3'd0, 4'd8, 4'd8, 4'd8, 1'b0, 16'd0, 0);
        send_directed("relu_trunc", 384, -1000, 1, 0, 0, 0);
        set_cfg(2'd2, 3'd3, 4'd8, 4'd8, 4'd8, 1'b1, 16'd0, 0);
        send_directed("leaky", -4096, -1024, -2, 0, 0, 0);
        set_cfg(2'd0, 3'd3, 4'd8, 4'd8, 4'd8, 1'b1, 16'd0, 0);
        send_directed("bypass", -1024, 1000, -4, 4, 0, 0);
        send_directed("saturate", 1073741824, -1073741824, 32767, -32768, 1, 1);
        set_cfg(2'd3, 3'd0, 4'd8, 4'd8, 4'd8, 1'b1, 16'd1536, 0);
        send_directed("clip", 655360, 196608, 1536, 768, 1, 0);
        set_cfg(2'd1, 3'd0, 4'd8, 4'd8, 4'd8, 1'b1, 16'd0, -256);
        send_directed("threshold", 0, -256, 1, 0, 0, 0);
        set_cfg(2'd1, 3'd0, 4'd0, 4'd0, 4'd15, 1'b1, 16'd0, 0);
        send_directed("shift_zero", 100, 40000, 100, 32767, 0, 1);

        // Backpressure: six back-to-back beats, out_ready low in cycles 4..9.
        set_cfg(2'd1, 3'd0, 4'd8, 4'd8, 4'd8, 1'b1, 16'd0, 0);
        for (int i = 0; i < 6; i++) beats[i] = rand_beat();
        sent = 0; cyc = 0; start = n_out;
        while (cyc < 40 && (n_out - start) < 6) begin
            bus.out_ready = !(cyc >= 4 && cyc <= 9);
            bus.in_valid  = (sent < 6);
            if (sent < 6) bus.in_data = beats[sent];
            @(negedge system_clk);
            if (cyc == 3) check("bp_in_ready_c3", bus.in_ready, 1);
            if (cyc == 4) check("bp_in_ready_c4", bus.in_ready, 0);
            if (cyc == 9) check("bp_in_ready_c9", bus.in_ready, 0);
            if (bus.in_valid && bus.in_ready) sent++;
            tick();
            cyc++;
        end
        check("bp_beats_out", n_out - start, 6);
        drain("bp");

        // Randomised configurations and traffic.
        for (int k = 0; k < 6; k++) begin
            set_cfg(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    16'($urandom_range(0, 65535)), longint'($signed(rand_lane())));
            bus.in_valid = 1'b0;
            for (int c = 0; c < 60; c++) begin
                if (!bus.in_valid && $urandom_range(0, 3) != 0) begin
                    bus.in_data  = rand_beat();
                    bus.in_valid = 1'b1;
                end
                bus.out_ready = ($urandom_range(0, 3) != 0);
                @(negedge system_clk);
                acc = int'(bus.in_valid && bus.in_ready);
                tick();
                if (acc != 0) bus.in_valid = 1'b0;
            end
            drain("rand");
        end

        // Reset in the middle of a stream discards everything in flight.
        set_cfg(2'd1, 3'd0, 4'd8, 4'd8, 4'd8, 1'b1, 16'd0, 0);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bus.in_data  = rand_beat();
            bus.in_valid = 1'b1;
            tick();
        end
        check("mid_out_valid_before_rst", bus.out_valid, 1);
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_out_data", bus.out_data, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        exp_q.delete();
        tick(); tick();
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        check("no_stale_after_rst", seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
